ram_op_sequencer: RTL and testbench

- Single-command sequencer that sits directly upstream of the dual-port operand RAM (ram, DATA=198, ADDR=6) and drives both of its ports.
- Per command it reads two GF(3^m) operands (mem[a] on port A, mem[b] on port B), optionally runs them through an external arithmetic unit via a start/done handshake, and writes the result to mem[c] on port A.
- Sits between the pairing controller (command source) and the RAM/ALU datapath.

---
 rtl/ram_op_sequencer_pkg.sv | 8 +
 rtl/ram_op_sequencer_if.sv | 46 ++++
 rtl/ram_op_sequencer.sv | 100 ++++++++++
 tb/tb_ram_op_sequencer.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_op_sequencer_pkg.sv
// ram_op_sequencer_pkg: opcodes, FSM state encoding and default widths
// shared by the RAM operation sequencer and its interface.
package ram_op_sequencer_pkg;
    localparam int DATA_W = 198;
    localparam int ADDR_W = 6;
    localparam logic [1:0] OP_COPY = 2'b00;
    typedef enum logic [2:0] {IDLE, READ, LATCH, EXEC, WAIT, WRITE} state_e;
endpackage

// File: rtl/ram_op_sequencer_if.sv
// ram_op_sequencer_if: command, dual-port RAM and ALU handshake signals;
// the sequencer is the slave side, the surrounding datapath the master.
interface ram_op_sequencer_if
    import ram_op_sequencer_pkg::*;
#(
    parameter int DATA = DATA_W,
    parameter int ADDR = ADDR_W
) ();
    logic            cmd_valid;
    logic            cmd_ready;
    logic [1:0]      cmd_op;
    logic [ADDR-1:0] cmd_a;
    logic [ADDR-1:0] cmd_b;
    logic [ADDR-1:0] cmd_c;
    logic            ram_a_wr;
    logic [ADDR-1:0] ram_a_addr;
    logic [DATA-1:0] ram_a_din;
    logic [DATA-1:0] ram_a_dout;
    logic            ram_b_wr;
    logic [ADDR-1:0] ram_b_addr;
    logic [DATA-1:0] ram_b_din;
    logic [DATA-1:0] ram_b_dout;
    logic            alu_start;
    logic [1:0]      alu_op;
    logic [DATA-1:0] alu_x;
    logic [DATA-1:0] alu_y;
    logic            alu_done;
    logic [DATA-1:0] alu_result;
    logic            done;

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_c,
        input  ram_a_dout, ram_b_dout, alu_done, alu_result,
        output cmd_ready, ram_a_wr, ram_a_addr, ram_a_din,
        output ram_b_wr, ram_b_addr, ram_b_din,
        output alu_start, alu_op, alu_x, alu_y, done
    );

    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_c,
        output ram_a_dout, ram_b_dout, alu_done, alu_result,
        input  cmd_ready, ram_a_wr, ram_a_addr, ram_a_din,
        input  ram_b_wr, ram_b_addr, ram_b_din,
        input  alu_start, alu_op, alu_x, alu_y, done
    );
endinterface

// File: rtl/ram_op_sequencer.sv
// ram_op_sequencer: reads mem[a]/mem[b], optionally runs them through the
// external ALU, and writes the result (or mem[a] for COPY) back to mem[c].
module ram_op_sequencer
    import ram_op_sequencer_pkg::*;
#(
    parameter int DATA = DATA_W,
    parameter int ADDR = ADDR_W
) (
    input logic clk,
    input logic reset_n,
    ram_op_sequencer_if.slave bus
);
    state_e          state_q, state_d;
    logic [1:0]      op_q, op_d;
    logic [ADDR-1:0] c_q, c_d;
    logic [ADDR-1:0] a_addr_q, a_addr_d;
    logic [ADDR-1:0] b_addr_q, b_addr_d;
    logic [DATA-1:0] x_q, x_d;
    logic [DATA-1:0] y_q, y_d;
    logic [DATA-1:0] din_q, din_d;
    logic            done_q, done_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            op_q     <= '0;
            c_q      <= '0;
            a_addr_q <= '0;
            b_addr_q <= '0;
            x_q      <= '0;
            y_q      <= '0;
            din_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            c_q      <= c_d;
            a_addr_q <= a_addr_d;
            b_addr_q <= b_addr_d;
            x_q      <= x_d;
            y_q      <= y_d;
            din_q    <= din_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        c_d      = c_q;
        a_addr_d = a_addr_q;
        b_addr_d = b_addr_q;
        x_d      = x_q;
        y_d      = y_q;
        din_d    = din_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: if (bus.cmd_valid) begin
                state_d  = READ;
                op_d     = bus.cmd_op;
                c_d      = bus.cmd_c;
                a_addr_d = bus.cmd_a;
                b_addr_d = bus.cmd_b;
            end
            READ: state_d = LATCH;
            LATCH: begin
                // COPY writes the port-A operand straight back; ALU ops overwrite din later
                x_d     = bus.ram_a_dout;
                y_d     = bus.ram_b_dout;
                din_d   = bus.ram_a_dout;
                state_d = (op_q == OP_COPY) ? WRITE : EXEC;
                a_addr_d = (op_q == OP_COPY) ? c_q : a_addr_q;
            end
            EXEC: state_d = WAIT;
            WAIT: if (bus.alu_done) begin
                din_d    = bus.alu_result;
                a_addr_d = c_q;
                state_d  = WRITE;
            end
            WRITE: begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.cmd_ready  = (state_q == IDLE);
    assign bus.ram_a_wr   = (state_q == WRITE);
    assign bus.ram_a_addr = a_addr_q;
    assign bus.ram_a_din  = din_q;
    assign bus.ram_b_wr   = 1'b0;
    assign bus.ram_b_addr = b_addr_q;
    assign bus.ram_b_din  = '0;
    assign bus.alu_start  = (state_q == EXEC);
    assign bus.alu_op     = op_q;
    assign bus.alu_x      = x_q;
    assign bus.alu_y      = y_q;
    assign bus.done       = done_q;
endmodule

// File: tb/tb_ram_op_sequencer.sv
// tb_ram_op_sequencer: sequencer with a behavioural dual-port RAM and a
// delay-configurable stub ALU; write-backs are checked against a scoreboard.
module tb_ram_op_sequencer;
    typedef struct {
        logic [5:0]   addr;
        logic [197:0] data;
    } wr_t;

    typedef struct {
        logic [1:0]   op;
        logic [5:0]   a, b, c;
        logic [197:0] va, vb, exp;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int tests = 0;
    int fails = 0;
    int cyc = 0;

    logic [197:0] mem [64];
    logic         pre_we = 1'b0;
    logic [5:0]   pre_addr = '0;
    logic [197:0] pre_data = '0;

    logic         alu_auto = 1'b1;
    int           alu_delay = 1;
    int           cnt = 0;
    logic         stub_done = 1'b0;
    logic [197:0] stub_res = '0;
    logic         man_done = 1'b0;
    logic [197:0] man_res = '0;

    wr_t sb[$];

    ram_op_sequencer_if ifc ();

    ram_op_sequencer dut (.clk(clk), .reset_n(reset_n), .bus(ifc.slave));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign ifc.alu_done   = stub_done | man_done;
    assign ifc.alu_result = man_done ? man_res : stub_res;

    always @(posedge clk) begin
        if (pre_we) mem[pre_addr] <= pre_data;
        else if (ifc.ram_a_wr) mem[ifc.ram_a_addr] <= ifc.ram_a_din;
        ifc.ram_a_dout <= mem[ifc.ram_a_addr];
        ifc.ram_b_dout <= mem[ifc.ram_b_addr];
    end

    function automatic logic [197:0] alu_model(input logic [1:0] op, input logic [197:0] x, y);
        return (op == 2'b01) ? x + y : (op == 2'b10) ? x ^ y : (op == 2'b11) ? x - y : '0;
    endfunction

    always @(posedge clk) begin
        stub_done <= 1'b0;
        if (alu_auto && ifc.alu_start) cnt <= alu_delay;
        else if (cnt != 0) begin
            cnt <= cnt - 1;
            if (cnt == 1) begin
                stub_done <= 1'b1;
                stub_res  <= alu_model(ifc.alu_op, ifc.alu_x, ifc.alu_y);
            end
        end
    end

    task automatic chk(input string name, input logic [197:0] act, input logic [197:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n && ifc.ram_a_wr) begin
            chk("port_b_write", ifc.ram_b_wr, 1'b0);
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL sb_unexpected_write: addr %0d data %h, expected no write", ifc.ram_a_addr, ifc.ram_a_din);
            end else begin
                wr_t e;
                e = sb.pop_front();
                if (ifc.ram_a_addr !== e.addr || ifc.ram_a_din !== e.data) begin
                    fails++;
                    $display("FAIL sb_write: addr %0d data %h expected addr %0d data %h", ifc.ram_a_addr, ifc.ram_a_din, e.addr, e.data);
                end
            end
        end
    end

    task automatic preload(input logic [5:0] a, input logic [197:0] d);
        @(negedge clk);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    // Returns just after the accepting edge T; the next negedge is in cycle T+1.
    task automatic issue(input logic [1:0] op, input logic [5:0] a, b, c);
        int n;
        @(negedge clk);
        ifc.cmd_op = op; ifc.cmd_a = a; ifc.cmd_b = b; ifc.cmd_c = c;
        ifc.cmd_valid = 1'b1;
        n = 0;
        while (!ifc.cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("accept_ready", ifc.cmd_ready, 1'b1);
        @(posedge clk);
        #1 ifc.cmd_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ifc.done && n < 60);
        chk("done_seen", ifc.done, 1'b1);
    endtask

    vec_t v[6];

    initial begin
        logic bad;
        int acc, n;
        int tacc[3];
        ifc.cmd_valid = 1'b0; ifc.cmd_op = '0;
        ifc.cmd_a = '0; ifc.cmd_b = '0; ifc.cmd_c = '0;

        v[0] = '{2'b00, 6'd10, 6'd11, 6'd12, 198'h123, 198'h9, 198'h123};
        v[1] = '{2'b01, 6'd13, 6'd14, 6'd15, 198'd100, 198'd23, 198'd123};
        v[2] = '{2'b10, 6'd16, 6'd17, 6'd16, 198'hF0, 198'h3C, 198'hCC};
        v[3] = '{2'b11, 6'd20, 6'd21, 6'd21, 198'd50, 198'd8, 198'd42};
        v[4] = '{2'b01, 6'd18, 6'd18, 6'd19, 198'd21, 198'd21, 198'd42};
        v[5] = '{2'b01, 6'd22, 6'd23, 6'd22, {1'b1, 197'd0}, {1'b1, 197'd0}, 198'd0};

        repeat (2) @(negedge clk);
        chk("rst_ready", ifc.cmd_ready, 1'b1);
        chk("rst_wr", ifc.ram_a_wr, 1'b0);
        chk("rst_start", ifc.alu_start, 1'b0);
        chk("rst_done", ifc.done, 1'b0);
        chk("rst_addr_a", ifc.ram_a_addr, '0);
        chk("rst_addr_b", ifc.ram_b_addr, '0);
        chk("rst_x", ifc.alu_x, '0);
        chk("rst_y", ifc.alu_y, '0);
        chk("rst_din", ifc.ram_a_din, '0);
        reset_n = 1'b1;
        bad = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (ifc.ram_a_wr || ifc.alu_start || ifc.done || !ifc.cmd_ready) bad = 1'b1;
        end
        chk("idle_quiet", bad, 1'b0);

        // COPY a=3 -> c=7 with exact cycle timing
        preload(6'd3, 198'h5);
        sb.push_back('{6'd7, 198'h5});
        issue(2'b00, 6'd3, 6'd0, 6'd7);
        @(negedge clk); chk("copy_t1_wr", ifc.ram_a_wr, 1'b0);
        @(negedge clk); chk("copy_t2_wr", ifc.ram_a_wr, 1'b0);
        @(negedge clk);
        chk("copy_t3_wr", ifc.ram_a_wr, 1'b1);
        chk("copy_t3_addr", ifc.ram_a_addr, 6'd7);
        chk("copy_t3_din", ifc.ram_a_din, 198'h5);
        chk("copy_t3_done", ifc.done, 1'b0);
        @(negedge clk);
        chk("copy_t4_done", ifc.done, 1'b1);
        chk("copy_t4_ready", ifc.cmd_ready, 1'b1);
        chk("copy_t4_wr", ifc.ram_a_wr, 1'b0);
        chk("copy_mem7", mem[7], 198'h5);

        // ALU add with c==b, 5-cycle stub
        preload(6'd1, 198'd9);
        preload(6'd2, 198'd4);
        alu_delay = 5;
        sb.push_back('{6'd2, 198'd13});
        issue(2'b01, 6'd1, 6'd2, 6'd2);
        repeat (2) @(negedge clk);
        chk("alu_t2_start", ifc.alu_start, 1'b0);
        @(negedge clk);
        chk("alu_t3_start", ifc.alu_start, 1'b1);
        chk("alu_x", ifc.alu_x, 198'd9);
        chk("alu_y", ifc.alu_y, 198'd4);
        chk("alu_op", ifc.alu_op, 2'b01);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (!ifc.alu_done) chk("alu_wait_nowr", ifc.ram_a_wr, 1'b0);
        end while (!ifc.alu_done && n < 20);
        chk("alu_done_seen", ifc.alu_done, 1'b1);
        @(negedge clk);
        chk("alu_wr", ifc.ram_a_wr, 1'b1);
        chk("alu_wr_addr", ifc.ram_a_addr, 6'd2);
        chk("alu_wr_din", ifc.ram_a_din, 198'd13);
        @(negedge clk);
        chk("alu_done_pulse", ifc.done, 1'b1);
        chk("alu_mem2", mem[2], 198'd13);

        // table-driven vectors, including aliasing and wrap-around
        for (int i = 0; i < 6; i++) begin
            preload(v[i].a, v[i].va);
            preload(v[i].b, v[i].vb);
            alu_delay = 1 + i;
            sb.push_back('{v[i].c, v[i].exp});
            issue(v[i].op, v[i].a, v[i].b, v[i].c);
            wait_done();
            chk($sformatf("vec%0d_mem", i), mem[v[i].c], v[i].exp);
        end

        // cmd_valid held for three COPYs: accepts only in IDLE, 4 cycles apart
        @(negedge clk);
        ifc.cmd_op = 2'b00; ifc.cmd_a = 6'd3; ifc.cmd_b = 6'd0; ifc.cmd_c = 6'd8;
        ifc.cmd_valid = 1'b1;
        acc = 0; n = 0;
        while (acc < 3 && n < 40) begin
            if (ifc.cmd_ready) begin
                tacc[acc] = cyc;
                acc++;
                sb.push_back('{6'd8, 198'h5});
            end
            @(negedge clk);
            n++;
        end
        ifc.cmd_valid = 1'b0;
        chk("held_accepts", acc, 3);
        chk("held_gap1", tacc[1] - tacc[0], 4);
        chk("held_gap2", tacc[2] - tacc[1], 4);
        wait_done();
        chk("held_mem8", mem[8], 198'h5);

        // reset during WAIT, late alu_done must be ignored
        alu_auto = 1'b0;
        preload(6'd30, 198'd7);
        preload(6'd31, 198'd1);
        preload(6'd32, 198'h77);
        issue(2'b01, 6'd30, 6'd31, 6'd32);
        repeat (3) @(negedge clk);
        chk("rstw_start", ifc.alu_start, 1'b1);
        @(negedge clk);
        reset_n = 1'b0;
        #1 chk("rstw_ready", ifc.cmd_ready, 1'b1);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        man_done = 1'b1; man_res = 198'hBAD;
        @(negedge clk);
        man_done = 1'b0;
        bad = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (ifc.ram_a_wr || ifc.done || !ifc.cmd_ready) bad = 1'b1;
        end
        chk("rstw_quiet", bad, 1'b0);
        chk("rstw_mem32", mem[32], 198'h77);

        // alu_done in EXEC is ignored; the pulse two cycles later is used
        preload(6'd40, 198'd3);
        preload(6'd41, 198'd4);
        sb.push_back('{6'd42, 198'h1234});
        issue(2'b01, 6'd40, 6'd41, 6'd42);
        repeat (3) @(negedge clk);
        chk("early_start", ifc.alu_start, 1'b1);
        man_done = 1'b1; man_res = 198'hDEAD;
        @(negedge clk);
        man_done = 1'b0;
        chk("early_t4_wr", ifc.ram_a_wr, 1'b0);
        @(negedge clk);
        chk("early_t5_wr", ifc.ram_a_wr, 1'b0);
        man_done = 1'b1; man_res = 198'h1234;
        @(negedge clk);
        man_done = 1'b0;
        chk("early_t6_wr", ifc.ram_a_wr, 1'b1);
        chk("early_t6_din", ifc.ram_a_din, 198'h1234);
        @(negedge clk);
        chk("early_t7_done", ifc.done, 1'b1);
        chk("early_mem42", mem[42], 198'h1234);

        repeat (2) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
